vending_machine_change: RTL
===========================

VENDING_MACHINE_CHANGE -- requirements
Module: vending_machine_change

Interface
REQ-001 SHALL have parameter PRICE_N, default 4: item price in nickel units (5 cents each); legal range 1..2^CREDIT_W-1.
REQ-002 SHALL have parameter CREDIT_W, default 8: credit register width in nickel units; MAX_CREDIT = 2^CREDIT_W-1.
REQ-003 SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port nickel, input, 1 bit: coin worth 1 unit this cycle.
REQ-006 SHALL have port dime, input, 1 bit: coin worth 2 units this cycle.
REQ-007 SHALL have port quarter, input, 1 bit: coin worth 5 units this cycle.
REQ-008 SHALL have port cancel, input, 1 bit: refund request.
REQ-009 SHALL have port vend_ack, input, 1 bit: dispenser accepted the item.
REQ-010 SHALL have port vend, output, 1 bit: dispense request, held until acknowledged.
REQ-011 SHALL have port change_nickel, output, 1 bit: one nickel returned per asserted cycle.
REQ-012 SHALL have port coin_reject, output, 1 bit: coins in the previous cycle were rejected.
REQ-013 SHALL have port credit, output, CREDIT_W bits: current registered credit in nickel units.
REQ-014 SHALL have port busy, output, 1 bit: high in VEND or CHANGE.

Function
REQ-015 SHALL implement states ACCEPT, VEND and CHANGE; vend, change_nickel and busy SHALL be Moore outputs decoded from state only.
REQ-016 In ACCEPT with cancel low, credit SHALL update to credit + nickel + 2*dime + 5*quarter; simultaneous coins SHALL be summed, and the sum SHALL be computed without truncation.
REQ-017 If the summed credit would exceed MAX_CREDIT, all coins that cycle SHALL be rejected, credit SHALL be unchanged, and coin_reject SHALL be high for exactly the next cycle.
REQ-018 In ACCEPT, when registered credit >= PRICE_N and cancel is low, the next state SHALL be VEND, so vend rises one cycle after credit reaches the price; coins presented in that same cycle SHALL still be accepted per REQ-016/REQ-017.
REQ-019 In ACCEPT, cancel high with credit > 0 SHALL go to CHANGE and reject any coins that cycle; cancel with credit == 0 SHALL be a no-op.
REQ-020 In VEND, vend SHALL stay 1 until vend_ack; on the ack cycle, credit SHALL become credit - PRICE_N.
REQ-021 On the VEND ack cycle, the next state SHALL be CHANGE if the remainder is > 0, else ACCEPT; without ack, the state SHALL remain VEND indefinitely.
REQ-022 In VEND, cancel SHALL be ignored.
REQ-023 In CHANGE, change_nickel SHALL be 1 every cycle and credit SHALL decrement by 1 per cycle; the cycle that takes credit from 1 to 0 SHALL be the last CHANGE cycle, followed by ACCEPT.
REQ-024 Any coin asserted in VEND or CHANGE SHALL be rejected, with coin_reject pulsed the next cycle and credit unaffected by the coin.
REQ-025 vend_ack outside VEND SHALL be ignored.

Reset
REQ-026 rst high SHALL immediately force state ACCEPT, credit 0, and vend, change_nickel, coin_reject and busy to 0, from any state including mid-VEND or mid-CHANGE.
REQ-027 After rst is released, no outstanding vend or change SHALL resume.

Verification (PRICE_N=4, CREDIT_W=8 unless stated)
REQ-028 Bench SHALL cover: nickel x4 over 4 cycles -> credit 1,2,3,4; vend=1 the next cycle; vend_ack -> credit 0, state ACCEPT, change_nickel never asserted.
REQ-029 Bench SHALL cover: single quarter -> credit 5, vend=1; vend_ack -> credit 1, one change_nickel cycle, then credit 0 and busy=0.
REQ-030 Bench SHALL cover: dime, then cancel with a nickel in the same cycle -> coin_reject pulse, two change_nickel cycles, credit 2->1->0.
REQ-031 Bench SHALL cover: dime during VEND with vend_ack held low for 3 cycles -> coin_reject one cycle later, credit stays 4, vend held for all 3 cycles.
REQ-032 Bench SHALL cover, with CREDIT_W=3 and PRICE_N=7: nickel+dime in one cycle -> credit 3; then quarter -> coin_reject, credit stays 3.
REQ-033 Bench SHALL cover: rst asserted during the second change_nickel cycle of a 4-unit refund -> outputs 0 asynchronously, credit 0, no change pulses after release.

Source files
------------

// File: rtl/vending_machine_change.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : vending_machine_change
// Description : Coin-accepting vending controller with single-item vend,
//               cancel refund and one-nickel-per-cycle change return.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module vending_machine_change #(
  parameter int PRICE_N  = 4,
  parameter int CREDIT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                nickel,
  input  logic                dime,
  input  logic                quarter,
  input  logic                cancel,
  input  logic                vend_ack,
  output logic                vend,
  output logic                change_nickel,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  // Four guard bits hold credit plus the largest single-cycle deposit (8).
  localparam int                SUM_W      = CREDIT_W + 4;
  localparam logic [SUM_W-1:0]  MAX_CREDIT = {4'b0000, {CREDIT_W{1'b1}}};
  localparam logic [CREDIT_W-1:0] PRICE    = CREDIT_W'(PRICE_N);
  localparam logic [CREDIT_W-1:0] ONE      = CREDIT_W'(1);

  typedef enum logic [1:0] {
    ST_ACCEPT = 2'd0,
    ST_VEND   = 2'd1,
    ST_CHANGE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                coin_reject_q, coin_reject_d;

  logic [3:0]          coin_val;
  logic [SUM_W-1:0]    coin_sum;
  logic                any_coin;
  logic                sum_ovf;

  always_comb begin
    coin_val = {3'b000, nickel} + {2'b00, dime, 1'b0} + {1'b0, quarter, 1'b0, quarter};
    coin_sum = {4'b0000, credit_q} + {{CREDIT_W{1'b0}}, coin_val};
    any_coin = nickel | dime | quarter;
    sum_ovf  = (coin_sum > MAX_CREDIT);
  end

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    coin_reject_d = 1'b0;
    case (state_q)
      ST_ACCEPT: begin
        if (cancel && (credit_q != '0)) begin
          state_d       = ST_CHANGE;
          coin_reject_d = any_coin;
        end else begin
          // Coins are still taken in the cycle the vend decision is made.
          if (sum_ovf) begin
            coin_reject_d = 1'b1;
          end else begin
            credit_d = coin_sum[CREDIT_W-1:0];
          end
          if (!cancel && (credit_q >= PRICE)) begin
            state_d = ST_VEND;
          end
        end
      end
      ST_VEND: begin
        coin_reject_d = any_coin;
        if (vend_ack) begin
          credit_d = credit_q - PRICE;
          state_d  = (credit_q > PRICE) ? ST_CHANGE : ST_ACCEPT;
        end
      end
      ST_CHANGE: begin
        coin_reject_d = any_coin;
        if (credit_q <= ONE) begin
          credit_d = '0;
          state_d  = ST_ACCEPT;
        end else begin
          credit_d = credit_q - ONE;
        end
      end
      default: begin
        state_d  = ST_ACCEPT;
        credit_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_ACCEPT;
      credit_q      <= '0;
      coin_reject_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      coin_reject_q <= coin_reject_d;
    end
  end

  assign vend          = (state_q == ST_VEND);
  assign change_nickel = (state_q == ST_CHANGE);
  assign busy          = (state_q == ST_VEND) || (state_q == ST_CHANGE);
  assign coin_reject   = coin_reject_q;
  assign credit        = credit_q;

endmodule
`default_nettype wire
